cntr8_cmd_ctrl: RTL and testbench

//   Front-end command conditioner that sits directly upstream of the 8-bit loadable counter.
//   It turns raw push-buttons (INC, LOAD) and slide switches (8-bit value) into clean,

---
 rtl/cntr8_cmd_ctrl.sv | 139 +++++++++++++
 tb/tb_cntr8_cmd_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr8_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cntr8_cmd_ctrl
// Purpose  : Command conditioner in front of the 8-bit loadable counter.
//            Synchronises, debounces and edge-detects the INC and LOAD
//            push-buttons, synchronises the switch bank, and emits clean
//            single-cycle inc/load strobes with a held load value. A load
//            and an inc that arrive together are serialised: load first,
//            inc on the following cycle.
// Ports    : clk      - system clock, rising edge
//            reset_n  - asynchronous active-low reset
//            btn_inc  - raw increment button (asynchronous, bouncy)
//            btn_load - raw load button (asynchronous, bouncy)
//            sw       - raw switch value (asynchronous), DATA_W bits
//            inc      - one-cycle increment strobe
//            load     - one-cycle load strobe
//            d_out    - value to load; valid while load=1, held afterwards
//            o_pend   - an increment is deferred behind a load
// Revision : 1.0 - initial release
// ============================================================================
module cntr8_cmd_ctrl #(
   parameter int DATA_W = 8,
   parameter int DB_CNT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              btn_inc,
   input  logic              btn_load,
   input  logic [DATA_W-1:0] sw,
   output logic              inc,
   output logic              load,
   output logic [DATA_W-1:0] d_out,
   output logic              o_pend
);

   // Counter value on which a disagreeing level is finally accepted.
   localparam logic [7:0] DB_LAST = 8'(DB_CNT - 1);

   // Button index 0 = inc, 1 = load.
   logic [1:0]        btn_raw;
   logic [1:0]        btn_s1_q;
   logic [1:0]        btn_s2_q;
   logic [DATA_W-1:0] sw_s1_q;
   logic [DATA_W-1:0] sw_s2_q;
   logic [1:0]        press_ev;

   assign btn_raw = {btn_load, btn_inc};

   // Two-flop synchronisers for both buttons and every switch bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn_raw;
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
      end
   end

   // Per-button debounce. The press event is taken from the accepting
   // transition itself, so the registered strobe appears on the same edge
   // that the debounced level goes high.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic [7:0] db_cnt_q;
         logic [7:0] db_cnt_d;
         logic       stable_q;
         logic       stable_d;
         logic       rise;

         always_comb begin
            db_cnt_d = '0;
            stable_d = stable_q;
            rise     = 1'b0;
            if (btn_s2_q[gi] != stable_q) begin
               if (db_cnt_q == DB_LAST) begin
                  stable_d = btn_s2_q[gi];
                  rise     = btn_s2_q[gi];
               end else begin
                  db_cnt_d = db_cnt_q + 8'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               db_cnt_q <= '0;
               stable_q <= 1'b0;
            end else begin
               db_cnt_q <= db_cnt_d;
               stable_q <= stable_d;
            end
         end

         assign press_ev[gi] = rise;
      end
   endgenerate

   // Strobe generation and load/inc arbitration.
   logic              inc_q,   inc_d;
   logic              load_q,  load_d;
   logic              pend_q,  pend_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;

   always_comb begin
      load_d  = press_ev[1];
      d_out_d = press_ev[1] ? sw_s2_q : d_out_q;
      // Load always wins the cycle; an inc that loses (new or already
      // deferred) is parked in the single pending slot.
      inc_d   = !press_ev[1] && (press_ev[0] || pend_q);
      pend_d  =  press_ev[1] && (press_ev[0] || pend_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inc_q   <= 1'b0;
         load_q  <= 1'b0;
         pend_q  <= 1'b0;
         d_out_q <= '0;
      end else begin
         inc_q   <= inc_d;
         load_q  <= load_d;
         pend_q  <= pend_d;
         d_out_q <= d_out_d;
      end
   end

   assign inc    = inc_q;
   assign load   = load_q;
   assign o_pend = pend_q;
   assign d_out  = d_out_q;

endmodule
`default_nettype wire

// File: tb/tb_cntr8_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntr8_cmd_ctrl
// Purpose  : Self-checking bench for cntr8_cmd_ctrl (DATA_W=8, DB_CNT=4).
//            A behavioural model (input history, run-length debounce,
//            request-count scheduler) is compared with the DUT on every
//            falling edge; directed scenarios pin exact strobe timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cntr8_cmd_ctrl;

   localparam int DATA_W = 8;
   localparam int DB_CNT = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              btn_inc = 1'b0;
   logic              btn_load = 1'b0;
   logic [DATA_W-1:0] sw = '0;
   logic              inc;
   logic              load;
   logic [DATA_W-1:0] d_out;
   logic              o_pend;

   int tests = 0;
   int fails = 0;

   cntr8_cmd_ctrl #(.DATA_W(DATA_W), .DB_CNT(DB_CNT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_inc (btn_inc),
      .btn_load(btn_load),
      .sw      (sw),
      .inc     (inc),
      .load    (load),
      .d_out   (d_out),
      .o_pend  (o_pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist[b] holds the last two raw samples; a level is accepted once the
   // synchronised value has disagreed with the accepted level for DB_CNT
   // consecutive edges. Increment requests are counted; a load takes the
   // output cycle and an increment is served on any cycle without a load.
   logic [1:0]        m_h1, m_h2;
   int                m_run [2];
   logic [1:0]        m_stb;
   logic [DATA_W-1:0] m_sw1, m_sw2;
   int                m_reqs;
   logic              m_inc, m_load, m_pend;
   logic [DATA_W-1:0] m_dout;

   initial begin
      m_h1 = '0; m_h2 = '0; m_stb = '0; m_sw1 = '0; m_sw2 = '0;
      m_run[0] = 0; m_run[1] = 0; m_reqs = 0;
      m_inc = 0; m_load = 0; m_pend = 0; m_dout = '0;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_h1 = '0; m_h2 = '0; m_stb = '0; m_sw1 = '0; m_sw2 = '0;
         m_run[0] = 0; m_run[1] = 0; m_reqs = 0;
         m_inc = 0; m_load = 0; m_pend = 0; m_dout = '0;
      end else begin
         logic [1:0] rose;
         logic [1:0] raw;
         raw  = {btn_load, btn_inc};
         rose = '0;
         for (int b = 0; b < 2; b++) begin
            if (m_h2[b] != m_stb[b]) begin
               m_run[b]++;
               if (m_run[b] == DB_CNT) begin
                  m_stb[b] = m_h2[b];
                  rose[b]  = m_h2[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         if (rose[0]) m_reqs++;
         if (rose[1]) begin
            m_load = 1'b1;
            m_dout = m_sw2;
            m_inc  = 1'b0;
         end else begin
            m_load = 1'b0;
            m_inc  = (m_reqs > 0);
            if (m_reqs > 0) m_reqs--;
         end
         m_pend = (m_reqs > 0);
         m_h2 = m_h1; m_h1 = raw;
         m_sw2 = m_sw1; m_sw1 = sw;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cmp_inc",    inc,    m_inc);
      chk("cmp_load",   load,   m_load);
      chk("cmp_pend",   o_pend, m_pend);
      chk("cmp_dout",   d_out,  m_dout);
      chk("cmp_excl",   inc & load, 1'b0);
      chk("cmp_onepend", (m_reqs <= 1), 1'b1);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      btn_inc  = 1'b0;
      btn_load = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      int rem_i;
      int rem_l;

      // 1: reset held with toggling inputs
      reset_n = 1'b0;
      for (int k = 0; k < 8; k++) begin
         btn_inc  = 1'($urandom);
         btn_load = 1'($urandom);
         sw       = 8'($urandom);
         tick();
         chk("t1_inc",  inc,    1'b0);
         chk("t1_load", load,   1'b0);
         chk("t1_pend", o_pend, 1'b0);
         chk("t1_dout", d_out,  8'h00);
      end
      btn_inc = 1'b0; btn_load = 1'b0; sw = 8'h00;
      reset_n = 1'b1;
      idle(8);

      // 2: clean press held 20 cycles
      btn_inc = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("t2_inc", inc, (k == 5));
      end
      btn_inc = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t2_rel", inc, 1'b0);
      end

      // 3: bouncing press
      for (int p = 0; p < 4; p++) begin
         btn_inc = (p % 2 == 0);
         repeat (2) begin
            tick();
            chk("t3_bounce", inc, 1'b0);
         end
      end
      btn_inc = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("t3_inc", inc, (k == 5));
      end
      idle(10);

      // 4: load captures switch value and holds it
      sw = 8'hA5;
      repeat (3) tick();
      btn_load = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("t4_load", load, (k == 5));
         if (k == 5) chk("t4_dout", d_out, 8'hA5);
      end
      sw = 8'h3C;
      btn_load = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t4_noload", load, 1'b0);
         chk("t4_hold", d_out, 8'hA5);
      end

      // 5: simultaneous presses
      btn_inc = 1'b1; btn_load = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("t5_load", load,   (k == 5));
         chk("t5_inc",  inc,    (k == 6));
         chk("t5_pend", o_pend, (k == 5));
      end
      idle(10);

      // 6: reset while a press is being debounced
      btn_inc = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_pre", inc, 1'b0);
      end
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("t6_rst_inc", inc, 1'b0);
         chk("t6_rst_ld",  load, 1'b0);
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("t6_inc", inc, (k == 6));
      end
      idle(10);

      // Randomised traffic against the model
      rem_i = 0;
      rem_l = 0;
      for (int n = 0; n < 4000; n++) begin
         if (rem_i == 0) begin
            btn_inc = 1'($urandom);
            rem_i   = $urandom_range(1, 10);
         end
         if (rem_l == 0) begin
            btn_load = 1'($urandom);
            rem_l    = $urandom_range(1, 10);
         end
         if ($urandom_range(0, 19) == 0) begin
            btn_inc = 1'b1; btn_load = 1'b1;
            rem_i = 12; rem_l = 12;
         end
         if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
         reset_n = ($urandom_range(0, 499) != 0);
         rem_i--;
         rem_l--;
         tick();
      end
      reset_n = 1'b1;
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
